// File: rtl/teatris_pkg.sv
// teatris_pkg: shared FSM encoding, button constants and widths for the TEAtris round controller
package teatris_pkg;
  typedef enum logic [2:0] {OCIOSO, ENDERECA, ESPERA, AVALIA, FIM} estado_t;
  localparam int BTN_W = 4;
  localparam int END_W = 4;
  localparam int PONTOS_W = 5;
  localparam int ERROS_W = 4;
  localparam logic [BTN_W-1:0] BTN1 = 4'b1000;
  localparam logic [BTN_W-1:0] BTN2 = 4'b0100;
  localparam logic [BTN_W-1:0] BTN3 = 4'b0010;
  localparam logic [BTN_W-1:0] BTN4 = 4'b0001;
  localparam logic [PONTOS_W-1:0] PONTOS_MAX = 5'd16;
  function automatic logic acertou(input logic [BTN_W-1:0] captura, input logic [BTN_W-1:0] esperada);
    return $onehot(captura) && captura == esperada;
  endfunction
endpackage

// File: rtl/teatris_sequenciador_jogadas_if.sv
// teatris_sequenciador_jogadas_if: buttons, play ROM and score/display signals of the round controller
interface teatris_sequenciador_jogadas_if;
  import teatris_pkg::*;
  logic                iniciar;
  logic [BTN_W-1:0]    botoes;
  logic [BTN_W-1:0]    jogada;
  logic [END_W-1:0]    endereco;
  logic [BTN_W-1:0]    jogada_esperada;
  logic                acerto;
  logic                erro;
  logic [PONTOS_W-1:0] pontos;
  logic [ERROS_W-1:0]  erros;
  logic                jogando;
  logic                fim;
  modport master (output iniciar, botoes, jogada,
                  input endereco, jogada_esperada, acerto, erro, pontos, erros, jogando, fim);
  modport slave (input iniciar, botoes, jogada,
                 output endereco, jogada_esperada, acerto, erro, pontos, erros, jogando, fim);
endinterface

// File: rtl/teatris_detector_borda.sv
// teatris_detector_borda: flags the cycle buttons leave the all-released state and captures the pattern
module teatris_detector_borda
  import teatris_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BTN_W-1:0] botoes,
  output logic             pressao,
  output logic [BTN_W-1:0] captura
);
  logic [BTN_W-1:0] hist_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) hist_q <= '0;
    else hist_q <= botoes;
  assign pressao = |botoes && hist_q == '0;
  assign captura = botoes;
endmodule

// File: rtl/teatris_sequenciador_jogadas.sv
// teatris_sequenciador_jogadas: steps the play ROM, times each pattern and judges hits/misses.
// TEATRIS_ACELERA_EN shortens the timeout after every group of 4 patterns.
module teatris_sequenciador_jogadas
  import teatris_pkg::*;
#(
  parameter int NUM_JOGADAS    = 16,
  parameter int MAX_ERROS      = 3,
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int TIMEOUT_DEC    = 5_000_000,
  parameter int TIMEOUT_MIN    = 10_000_000
) (
  input logic clock,
  input logic reset_n,
  teatris_sequenciador_jogadas_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  if (NUM_JOGADAS < 1 || NUM_JOGADAS > 16 || MAX_ERROS < 1 || MAX_ERROS > 15 ||
      TIMEOUT_CICLOS < 1 || TIMEOUT_MIN < 1 || TIMEOUT_DEC < 0) begin : g_param_invalido
    $error("teatris_sequenciador_jogadas: parameter out of range");
  end
  estado_t             estado_q, estado_d;
  logic [END_W-1:0]    endereco_q, endereco_d;
  logic [BTN_W-1:0]    esperada_q, esperada_d;
  logic [PONTOS_W-1:0] pontos_q, pontos_d;
  logic [ERROS_W-1:0]  erros_q, erros_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                acerto_q, acerto_d, erro_q, erro_d, jogando_q, jogando_d, fim_q, fim_d;
  logic [TW-1:0]       timeout_atual;
  logic                pressao;
  logic [BTN_W-1:0]    captura;
`ifdef TEATRIS_ACELERA_EN
  logic [TW-1:0]       timeout_q, timeout_d;
  assign timeout_atual = timeout_q;
`else
  assign timeout_atual = TW'(TIMEOUT_CICLOS);
`endif

  teatris_detector_borda u_borda (
    .clock   (clock),
    .reset_n (reset_n),
    .botoes  (bus.botoes),
    .pressao (pressao),
    .captura (captura)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    esperada_d = esperada_q;
    pontos_d   = pontos_q;
    erros_d    = erros_q;
    timer_d    = timer_q;
    acerto_d   = 1'b0;
    erro_d     = 1'b0;
`ifdef TEATRIS_ACELERA_EN
    timeout_d  = timeout_q;
`endif
    case (estado_q)
      OCIOSO, FIM:
        if (bus.iniciar) begin
          estado_d   = ENDERECA;
          endereco_d = '0;
          pontos_d   = '0;
          erros_d    = '0;
`ifdef TEATRIS_ACELERA_EN
          timeout_d  = TW'(TIMEOUT_CICLOS);
`endif
        end
      ENDERECA: begin
        estado_d   = ESPERA;
        esperada_d = bus.jogada;
        timer_d    = timeout_atual;
      end
      ESPERA: begin
        timer_d = timer_q - TW'(1);
        if (pressao || timer_q == TW'(1)) begin
          estado_d = AVALIA;
          acerto_d = pressao && acertou(captura, esperada_q);
          erro_d   = !acerto_d;
          pontos_d = (acerto_d && pontos_q != PONTOS_MAX) ? pontos_q + PONTOS_W'(1) : pontos_q;
          erros_d  = erros_q + ERROS_W'(erro_d);
        end
      end
      AVALIA:
        if (erros_q == ERROS_W'(MAX_ERROS) || endereco_q == END_W'(NUM_JOGADAS - 1))
          estado_d = FIM;
        else begin
          estado_d   = ENDERECA;
          endereco_d = endereco_q + END_W'(1);
`ifdef TEATRIS_ACELERA_EN
          if (endereco_q[1:0] == 2'd3)
            timeout_d = (int'(timeout_q) >= TIMEOUT_MIN + TIMEOUT_DEC) ?
                        timeout_q - TW'(TIMEOUT_DEC) : TW'(TIMEOUT_MIN);
`endif
        end
      default: estado_d = OCIOSO;
    endcase
    jogando_d = estado_d == ENDERECA || estado_d == ESPERA || estado_d == AVALIA;
    fim_d     = estado_d == FIM;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      esperada_q <= '0;
      pontos_q   <= '0;
      erros_q    <= '0;
      timer_q    <= '0;
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
      jogando_q  <= 1'b0;
      fim_q      <= 1'b0;
`ifdef TEATRIS_ACELERA_EN
      timeout_q  <= TW'(TIMEOUT_CICLOS);
`endif
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      esperada_q <= esperada_d;
      pontos_q   <= pontos_d;
      erros_q    <= erros_d;
      timer_q    <= timer_d;
      acerto_q   <= acerto_d;
      erro_q     <= erro_d;
      jogando_q  <= jogando_d;
      fim_q      <= fim_d;
`ifdef TEATRIS_ACELERA_EN
      timeout_q  <= timeout_d;
`endif
    end

  // the address leads the state by one edge so the synchronous ROM has data by the end of ENDERECA
  assign bus.endereco        = endereco_d;
  assign bus.jogada_esperada = esperada_q;
  assign bus.acerto          = acerto_q;
  assign bus.erro            = erro_q;
  assign bus.pontos          = pontos_q;
  assign bus.erros           = erros_q;
  assign bus.jogando         = jogando_q;
  assign bus.fim             = fim_q;
endmodule
